// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes, ALU ops, mux selects.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ctrl_pkg;

    localparam logic [3:0] S_BOOT     = 4'd0,
                           S_FETCH    = 4'd1,
                           S_DECODE   = 4'd2,
                           S_MEMADR   = 4'd3,
                           S_MEMREAD  = 4'd4,
                           S_MEMWB    = 4'd5,
                           S_MEMWRITE = 4'd6,
                           S_EXECR    = 4'd7,
                           S_EXECI    = 4'd8,
                           S_ALUWB    = 4'd9,
                           S_BRANCH   = 4'd10,
                           S_JAL      = 4'd11,
                           S_JALR     = 4'd12,
                           S_LINK     = 4'd13,
                           S_LUI      = 4'd14,
                           S_TRAP     = 4'd15;

    localparam logic [6:0] OP_LOAD   = 7'b0000011,
                           OP_STORE  = 7'b0100011,
                           OP_R      = 7'b0110011,
                           OP_I      = 7'b0010011,
                           OP_BRANCH = 7'b1100011,
                           OP_JAL    = 7'b1101111,
                           OP_JALR   = 7'b1100111,
                           OP_LUI    = 7'b0110111,
                           OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000,
                           ALU_SUB  = 4'b0001,
                           ALU_AND  = 4'b0010,
                           ALU_OR   = 4'b0011,
                           ALU_XOR  = 4'b0100,
                           ALU_SLL  = 4'b0101,
                           ALU_SRA  = 4'b0110,
                           ALU_SRL  = 4'b0111,
                           ALU_SLT  = 4'b1000,
                           ALU_SLTU = 4'b1001;

    localparam logic [1:0] SRCA_PC    = 2'b00,
                           SRCA_OLDPC = 2'b01,
                           SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00,
                           SRCB_IMM  = 2'b01,
                           SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00,
                           RES_DATA   = 2'b01,
                           RES_ALU    = 2'b10,
                           RES_IMM    = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000,
                           IMM_S = 3'b001,
                           IMM_B = 3'b010,
                           IMM_J = 3'b011,
                           IMM_U = 3'b100;

    localparam logic [1:0] SIZE_BYTE = 2'b00,
                           SIZE_HALF = 2'b01,
                           SIZE_WORD = 2'b10;

    // Moore control bundle; the Mealy enables (ir_write, pc_write) live outside it.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic [3:0] alu_control;
        logic [1:0] mem_size;
        logic       mem_unsigned;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps op/funct3/funct7 to the ALU operation for R-type and I-type ALU instructions.
// Latency: combinational.
// Backpressure: none.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        if (op == OP_R || op == OP_I) begin
            case (funct3)
                // IR[30] on addi is an immediate bit, so only R-type can subtract.
                3'b000:  alu_control = (op == OP_R && funct7) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_control = ALU_SLL;
                3'b010:  alu_control = ALU_SLT;
                3'b011:  alu_control = ALU_SLTU;
                3'b100:  alu_control = ALU_XOR;
                3'b101:  alu_control = funct7 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_control = ALU_OR;
                default: alu_control = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback with sticky traps.
// Latency: 3-5 cycles per instruction plus one per memory wait cycle.
// Backpressure: mem_req held until mem_ready; a stall of MEM_WAIT_MAX cycles traps.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter bit SUPPORT_HALF = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       mem_ready,
    input  logic       cmp_taken,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic [1:0] mem_size,
    output logic       mem_unsigned,
    output logic       illegal,
    output logic       bus_err,
    output logic [3:0] state_o
);

    localparam int CNT_W = (MEM_WAIT_MAX > 0) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [3:0]       decode_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [3:0]       alu_dec;
    logic             half_ok;
    logic             stall;
    logic             timeout;
    ctrl_t            c;
    logic             ir_write_c;
    logic             pc_write_c;

    assign half_ok = SUPPORT_HALF;

    alu_decoder u_alu_decoder (
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .alu_control (alu_dec)
    );

    // Dispatch target out of DECODE; S_TRAP marks an illegal encoding.
    always_comb begin
        decode_nxt = S_TRAP;
        case (op)
            OP_LOAD: begin
                case (funct3)
                    3'b000, 3'b010, 3'b100: decode_nxt = S_MEMADR;
                    3'b001, 3'b101:         decode_nxt = half_ok ? S_MEMADR : S_TRAP;
                    default:                decode_nxt = S_TRAP;
                endcase
            end
            OP_STORE: begin
                case (funct3)
                    3'b000, 3'b010: decode_nxt = S_MEMADR;
                    3'b001:         decode_nxt = half_ok ? S_MEMADR : S_TRAP;
                    default:        decode_nxt = S_TRAP;
                endcase
            end
            OP_R: begin
                if (!funct7 || funct3 == 3'b000 || funct3 == 3'b101)
                    decode_nxt = S_EXECR;
            end
            OP_I: begin
                if (funct3 != 3'b001 || !funct7)
                    decode_nxt = S_EXECI;
            end
            OP_BRANCH: begin
                if (funct3[2:1] != 2'b01)
                    decode_nxt = S_BRANCH;
            end
            OP_JAL:  decode_nxt = S_JAL;
            OP_JALR: begin
                if (funct3 == 3'b000)
                    decode_nxt = S_JALR;
            end
            OP_LUI:   decode_nxt = S_LUI;
            OP_AUIPC: decode_nxt = S_ALUWB;
            default:  decode_nxt = S_TRAP;
        endcase
    end

    assign stall   = c.mem_req && !mem_ready;
    // The MEM_WAIT_MAX-th consecutive stalled cycle is the last one tolerated.
    assign timeout = (MEM_WAIT_MAX > 0) && stall && (int'(wait_cnt) == MEM_WAIT_MAX - 1);

    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:     state_nxt = S_FETCH;
            S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
            S_DECODE:   state_nxt = decode_nxt;
            S_MEMADR:   state_nxt = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            S_JALR:     state_nxt = S_LINK;
            S_LINK:     state_nxt = S_FETCH;
            S_LUI:      state_nxt = S_FETCH;
            default:    state_nxt = S_TRAP;
        endcase
        if (timeout)
            state_nxt = S_TRAP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_BOOT;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!stall || timeout || state_nxt != state)
                wait_cnt <= '0;
            else if (MEM_WAIT_MAX > 0)
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (state == S_DECODE && decode_nxt == S_TRAP)
                illegal <= 1'b1;
            if (timeout)
                bus_err <= 1'b1;
        end
    end

    always_comb begin
        c          = '0;
        ir_write_c = 1'b0;
        pc_write_c = 1'b0;
        case (state)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALU;
                c.mem_size   = SIZE_WORD;
                ir_write_c   = mem_ready;
                pc_write_c   = mem_ready;
            end
            S_DECODE: begin
                // ALUOut <= OldPC + imm serves as branch/JAL target and AUIPC result.
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                case (op)
                    OP_BRANCH:       c.imm_src = IMM_B;
                    OP_JAL:          c.imm_src = IMM_J;
                    OP_LUI,
                    OP_AUIPC:        c.imm_src = IMM_U;
                    default:         c.imm_src = IMM_I;
                endcase
            end
            S_MEMADR: begin
                c.alu_src_a    = SRCA_RS1;
                c.alu_src_b    = SRCB_IMM;
                c.imm_src      = (op == OP_STORE) ? IMM_S : IMM_I;
                c.mem_size     = funct3[1:0];
                c.mem_unsigned = (op == OP_LOAD) && funct3[2];
            end
            S_MEMREAD: begin
                c.mem_req      = 1'b1;
                c.adr_src      = 1'b1;
                c.mem_size     = funct3[1:0];
                c.mem_unsigned = (op == OP_LOAD) && funct3[2];
            end
            S_MEMWB: begin
                c.result_src   = RES_DATA;
                c.reg_write    = 1'b1;
                c.mem_size     = funct3[1:0];
                c.mem_unsigned = (op == OP_LOAD) && funct3[2];
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
                c.mem_size  = funct3[1:0];
            end
            S_EXECR: begin
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_RS2;
                c.alu_control = alu_dec;
            end
            S_EXECI: begin
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_IMM;
                c.imm_src     = IMM_I;
                c.alu_control = alu_dec;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_RS2;
                c.alu_control = ALU_SUB;
                c.result_src  = RES_ALUOUT;
                pc_write_c    = cmp_taken;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                pc_write_c   = 1'b1;
            end
            S_JALR: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_IMM;
                c.imm_src    = IMM_I;
                c.result_src = RES_ALU;
                pc_write_c   = 1'b1;
            end
            S_LINK: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALU;
                c.reg_write  = 1'b1;
            end
            S_LUI: begin
                c.result_src = RES_IMM;
                c.imm_src    = IMM_U;
                c.reg_write  = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
    end

    assign mem_req      = c.mem_req;
    assign mem_write    = c.mem_write;
    assign adr_src      = c.adr_src;
    assign reg_write    = c.reg_write;
    assign alu_src_a    = c.alu_src_a;
    assign alu_src_b    = c.alu_src_b;
    assign result_src   = c.result_src;
    assign imm_src      = c.imm_src;
    assign alu_control  = c.alu_control;
    assign mem_size     = c.mem_size;
    assign mem_unsigned = c.mem_unsigned;
    assign ir_write     = ir_write_c;
    assign pc_write     = pc_write_c;
    assign state_o      = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: dut_a uses defaults, dut_b has a 4-cycle timeout and no halfwords.
module tb_multicycle_control;

    localparam logic [3:0] S_BOOT = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                           S_MEMREAD = 4'd4, S_MEMWB = 4'd5, S_MEMWRITE = 4'd6, S_EXECR = 4'd7,
                           S_EXECI = 4'd8, S_ALUWB = 4'd9, S_BRANCH = 4'd10, S_JAL = 4'd11,
                           S_JALR = 4'd12, S_LINK = 4'd13, S_LUI = 4'd14, S_TRAP = 4'd15;
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                           OP_I = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = OP_R;
    logic [2:0] funct3 = 3'd0;
    logic       funct7 = 1'b0;
    logic       mem_ready = 1'b0;
    logic       cmp_taken = 1'b0;

    logic a_mem_req, a_mem_write, a_adr_src, a_ir_write, a_pc_write, a_reg_write;
    logic [1:0] a_alu_src_a, a_alu_src_b, a_result_src, a_mem_size;
    logic [2:0] a_imm_src;
    logic [3:0] a_alu_control, a_state;
    logic a_mem_unsigned, a_illegal, a_bus_err;

    logic b_mem_req, b_mem_write, b_adr_src, b_ir_write, b_pc_write, b_reg_write;
    logic [1:0] b_alu_src_a, b_alu_src_b, b_result_src, b_mem_size;
    logic [2:0] b_imm_src;
    logic [3:0] b_alu_control, b_state;
    logic b_mem_unsigned, b_illegal, b_bus_err;

    logic [27:0] a_outs;
    assign a_outs = {a_mem_req, a_mem_write, a_adr_src, a_ir_write, a_pc_write, a_reg_write,
                     a_alu_src_a, a_alu_src_b, a_result_src, a_imm_src, a_alu_control,
                     a_mem_size, a_mem_unsigned, a_illegal, a_bus_err, a_state};

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    multicycle_control dut_a (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .cmp_taken(cmp_taken),
        .mem_req(a_mem_req), .mem_write(a_mem_write), .adr_src(a_adr_src),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .reg_write(a_reg_write),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .result_src(a_result_src),
        .imm_src(a_imm_src), .alu_control(a_alu_control), .mem_size(a_mem_size),
        .mem_unsigned(a_mem_unsigned), .illegal(a_illegal), .bus_err(a_bus_err),
        .state_o(a_state)
    );

    multicycle_control #(.MEM_WAIT_MAX(4), .SUPPORT_HALF(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .cmp_taken(cmp_taken),
        .mem_req(b_mem_req), .mem_write(b_mem_write), .adr_src(b_adr_src),
        .ir_write(b_ir_write), .pc_write(b_pc_write), .reg_write(b_reg_write),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .result_src(b_result_src),
        .imm_src(b_imm_src), .alu_control(b_alu_control), .mem_size(b_mem_size),
        .mem_unsigned(b_mem_unsigned), .illegal(b_illegal), .bus_err(b_bus_err),
        .state_o(b_state)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        op = OP_R; funct3 = 3'd0; funct7 = 1'b0; mem_ready = 1'b0; cmp_taken = 1'b0;
        @(negedge clk); rst_n = 1'b0; #1;
        total++; if (a_outs !== 28'd0) begin bad++; $display("FAIL reset_outs got=%h exp=0", a_outs); end
        @(negedge clk); rst_n = 1'b1; #1;
        total++; if (a_state !== S_BOOT) begin bad++; $display("FAIL boot_hold got=%0d exp=%0d", a_state, S_BOOT); end
        cyc();
        total++; if (a_state !== S_FETCH) begin bad++; $display("FAIL fetch_state got=%0d exp=%0d", a_state, S_FETCH); end
        total++; if ({a_mem_req, a_adr_src, a_alu_src_a, a_alu_src_b, a_result_src, a_ir_write, a_pc_write} !== 10'b1_0_00_10_10_00)
            begin bad++; $display("FAIL fetch_ctrl_stall got=%b exp=1000101000", {a_mem_req, a_adr_src, a_alu_src_a, a_alu_src_b, a_result_src, a_ir_write, a_pc_write}); end
        mem_ready = 1'b1; #1;
        total++; if ({a_ir_write, a_pc_write} !== 2'b11) begin bad++; $display("FAIL fetch_mealy got=%b exp=11", {a_ir_write, a_pc_write}); end
    endtask

    task automatic test_add();
        logic [3:0] seq [5];
        int writes;
        seq = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH};
        writes = 0;
        op = OP_R; funct3 = 3'd0; funct7 = 1'b0; mem_ready = 1'b1;
        do_reset();
        total++; if (a_state !== S_BOOT) begin bad++; $display("FAIL add_boot got=%0d exp=%0d", a_state, S_BOOT); end
        for (int i = 0; i < 5; i++) begin
            cyc();
            total++; if (a_state !== seq[i]) begin bad++; $display("FAIL add_seq%0d got=%0d exp=%0d", i, a_state, seq[i]); end
            if (a_reg_write === 1'b1) writes++;
            if (i == 1) begin
                total++; if ({a_alu_src_a, a_alu_src_b, a_imm_src, a_reg_write} !== 8'b01_01_000_0)
                    begin bad++; $display("FAIL add_decode got=%b exp=01010000", {a_alu_src_a, a_alu_src_b, a_imm_src, a_reg_write}); end
            end
            if (i == 2) begin
                total++; if ({a_alu_control, a_alu_src_a, a_alu_src_b} !== 8'b0000_10_00)
                    begin bad++; $display("FAIL add_exec got=%b exp=00001000", {a_alu_control, a_alu_src_a, a_alu_src_b}); end
            end
            if (i == 3) begin
                total++; if (a_result_src !== 2'b00) begin bad++; $display("FAIL add_wb_res got=%b exp=00", a_result_src); end
            end
        end
        total++; if (writes != 1) begin bad++; $display("FAIL add_reg_write_cycles got=%0d exp=1", writes); end
    endtask

    task automatic test_alu_decode();
        logic [14:0] tbl [12];
        logic [14:0] v;
        logic [3:0]  exp_st;
        tbl = '{{OP_R, 3'd0, 1'b1, 4'b0001}, {OP_R, 3'd1, 1'b0, 4'b0101},
                {OP_R, 3'd2, 1'b0, 4'b1000}, {OP_R, 3'd3, 1'b0, 4'b1001},
                {OP_R, 3'd4, 1'b0, 4'b0100}, {OP_R, 3'd5, 1'b0, 4'b0111},
                {OP_R, 3'd5, 1'b1, 4'b0110}, {OP_R, 3'd6, 1'b0, 4'b0011},
                {OP_R, 3'd7, 1'b0, 4'b0010}, {OP_I, 3'd0, 1'b1, 4'b0000},
                {OP_I, 3'd5, 1'b1, 4'b0110}, {OP_I, 3'd4, 1'b0, 4'b0100}};
        mem_ready = 1'b1;
        do_reset();
        cyc();
        for (int i = 0; i < 12; i++) begin
            v = tbl[i];
            op = v[14:8]; funct3 = v[7:5]; funct7 = v[4];
            exp_st = (v[14:8] == OP_R) ? S_EXECR : S_EXECI;
            cyc(); cyc();
            total++; if (a_state !== exp_st) begin bad++; $display("FAIL alu%0d_state got=%0d exp=%0d", i, a_state, exp_st); end
            total++; if (a_alu_control !== v[3:0]) begin bad++; $display("FAIL alu%0d_ctrl got=%b exp=%b", i, a_alu_control, v[3:0]); end
            cyc(); cyc();
        end
    endtask

    task automatic test_lbu();
        int reqs;
        reqs = 0;
        op = OP_LOAD; funct3 = 3'b100; funct7 = 1'b0; mem_ready = 1'b1;
        do_reset();
        cyc(); cyc();
        total++; if (a_state !== S_DECODE) begin bad++; $display("FAIL lbu_decode got=%0d exp=%0d", a_state, S_DECODE); end
        cyc();
        total++; if ({a_state, a_alu_src_a, a_alu_src_b, a_imm_src} !== {S_MEMADR, 7'b10_01_000})
            begin bad++; $display("FAIL lbu_memadr got=%b exp=%b", {a_state, a_alu_src_a, a_alu_src_b, a_imm_src}, {S_MEMADR, 7'b10_01_000}); end
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            mem_ready = (i == 3);
            #1;
            total++; if (a_state !== S_MEMREAD) begin bad++; $display("FAIL lbu_read%0d got=%0d exp=%0d", i, a_state, S_MEMREAD); end
            if (a_mem_req === 1'b1) reqs++;
            if (i == 0) begin
                total++; if ({a_adr_src, a_mem_write, a_mem_size, a_mem_unsigned} !== 5'b1_0_00_1)
                    begin bad++; $display("FAIL lbu_req_attrs got=%b exp=10001", {a_adr_src, a_mem_write, a_mem_size, a_mem_unsigned}); end
            end
        end
        total++; if (reqs != 4) begin bad++; $display("FAIL lbu_req_cycles got=%0d exp=4", reqs); end
        cyc();
        total++; if ({a_state, a_result_src, a_reg_write, a_mem_req} !== {S_MEMWB, 4'b01_1_0})
            begin bad++; $display("FAIL lbu_memwb got=%b exp=%b", {a_state, a_result_src, a_reg_write, a_mem_req}, {S_MEMWB, 4'b01_1_0}); end
        cyc();
        total++; if (a_state !== S_FETCH) begin bad++; $display("FAIL lbu_done got=%0d exp=%0d", a_state, S_FETCH); end
    endtask

    task automatic test_branch();
        op = OP_BRANCH; funct3 = 3'b000; funct7 = 1'b0; mem_ready = 1'b1; cmp_taken = 1'b0;
        do_reset();
        cyc();
        for (int t = 0; t < 2; t++) begin
            cmp_taken = (t == 1);
            cyc();
            total++; if ({a_state, a_imm_src} !== {S_DECODE, 3'b010}) begin bad++; $display("FAIL br%0d_decode got=%b exp=%b", t, {a_state, a_imm_src}, {S_DECODE, 3'b010}); end
            cyc();
            total++; if ({a_state, a_alu_control, a_alu_src_a, a_alu_src_b, a_result_src} !== {S_BRANCH, 10'b0001_10_00_00})
                begin bad++; $display("FAIL br%0d_ctrl got=%b exp=%b", t, {a_state, a_alu_control, a_alu_src_a, a_alu_src_b, a_result_src}, {S_BRANCH, 10'b0001_10_00_00}); end
            total++; if (a_pc_write !== (t == 1)) begin bad++; $display("FAIL br%0d_pc_write got=%b exp=%0d", t, a_pc_write, t); end
            cyc();
            total++; if (a_state !== S_FETCH) begin bad++; $display("FAIL br%0d_done got=%0d exp=%0d", t, a_state, S_FETCH); end
        end
        cmp_taken = 1'b0;
    endtask

    task automatic test_jumps_upper();
        op = OP_JALR; funct3 = 3'b000; funct7 = 1'b0; mem_ready = 1'b1;
        do_reset();
        cyc(); cyc();
        total++; if ({a_imm_src, a_alu_src_a, a_alu_src_b} !== 7'b000_01_01) begin bad++; $display("FAIL jalr_decode got=%b exp=0000101", {a_imm_src, a_alu_src_a, a_alu_src_b}); end
        cyc();
        total++; if ({a_state, a_alu_src_a, a_alu_src_b, a_result_src, a_pc_write, a_reg_write} !== {S_JALR, 8'b10_01_10_1_0})
            begin bad++; $display("FAIL jalr_state got=%b exp=%b", {a_state, a_alu_src_a, a_alu_src_b, a_result_src, a_pc_write, a_reg_write}, {S_JALR, 8'b10_01_10_1_0}); end
        cyc();
        total++; if ({a_state, a_alu_src_a, a_alu_src_b, a_result_src, a_pc_write, a_reg_write} !== {S_LINK, 8'b01_10_10_0_1})
            begin bad++; $display("FAIL link_state got=%b exp=%b", {a_state, a_alu_src_a, a_alu_src_b, a_result_src, a_pc_write, a_reg_write}, {S_LINK, 8'b01_10_10_0_1}); end
        cyc();
        op = OP_AUIPC;
        cyc();
        total++; if ({a_state, a_imm_src, a_alu_src_a, a_alu_src_b, a_alu_control} !== {S_DECODE, 11'b100_01_01_0000})
            begin bad++; $display("FAIL auipc_decode got=%b exp=%b", {a_state, a_imm_src, a_alu_src_a, a_alu_src_b, a_alu_control}, {S_DECODE, 11'b100_01_01_0000}); end
        cyc();
        total++; if ({a_state, a_result_src, a_reg_write} !== {S_ALUWB, 3'b00_1}) begin bad++; $display("FAIL auipc_wb got=%b exp=%b", {a_state, a_result_src, a_reg_write}, {S_ALUWB, 3'b00_1}); end
        cyc();
        op = OP_JAL;
        cyc();
        total++; if (a_imm_src !== 3'b011) begin bad++; $display("FAIL jal_imm got=%b exp=011", a_imm_src); end
        cyc();
        total++; if ({a_state, a_alu_src_a, a_alu_src_b, a_result_src, a_pc_write} !== {S_JAL, 7'b01_10_00_1})
            begin bad++; $display("FAIL jal_state got=%b exp=%b", {a_state, a_alu_src_a, a_alu_src_b, a_result_src, a_pc_write}, {S_JAL, 7'b01_10_00_1}); end
        cyc();
        total++; if (a_state !== S_ALUWB) begin bad++; $display("FAIL jal_wb got=%0d exp=%0d", a_state, S_ALUWB); end
        cyc();
        op = OP_LUI;
        cyc(); cyc();
        total++; if ({a_state, a_result_src, a_imm_src, a_reg_write} !== {S_LUI, 6'b11_100_1})
            begin bad++; $display("FAIL lui_state got=%b exp=%b", {a_state, a_result_src, a_imm_src, a_reg_write}, {S_LUI, 6'b11_100_1}); end
        cyc();
        total++; if (a_state !== S_FETCH) begin bad++; $display("FAIL lui_done got=%0d exp=%0d", a_state, S_FETCH); end
    endtask

    task automatic test_store_reset();
        op = OP_STORE; funct3 = 3'b001; funct7 = 1'b0; mem_ready = 1'b1;
        do_reset();
        cyc(); cyc();
        mem_ready = 1'b0;
        cyc();
        total++; if ({a_state, a_imm_src} !== {S_MEMADR, 3'b001}) begin bad++; $display("FAIL sh_memadr got=%b exp=%b", {a_state, a_imm_src}, {S_MEMADR, 3'b001}); end
        total++; if ({b_state, b_illegal} !== {S_TRAP, 1'b1}) begin bad++; $display("FAIL sh_nohalf got=%b exp=%b", {b_state, b_illegal}, {S_TRAP, 1'b1}); end
        cyc();
        total++; if ({a_state, a_mem_req, a_mem_write, a_adr_src, a_mem_size, a_mem_unsigned} !== {S_MEMWRITE, 6'b1_1_1_01_0})
            begin bad++; $display("FAIL sh_write got=%b exp=%b", {a_state, a_mem_req, a_mem_write, a_adr_src, a_mem_size, a_mem_unsigned}, {S_MEMWRITE, 6'b1_1_1_01_0}); end
        cyc();
        total++; if ({a_state, a_mem_req} !== {S_MEMWRITE, 1'b1}) begin bad++; $display("FAIL sh_hold got=%b exp=%b", {a_state, a_mem_req}, {S_MEMWRITE, 1'b1}); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (a_outs !== 28'd0) begin bad++; $display("FAIL sh_async_reset got=%h exp=0", a_outs); end
    endtask

    task automatic test_illegal();
        op = OP_LOAD; funct3 = 3'b001; funct7 = 1'b0; mem_ready = 1'b1;
        do_reset();
        cyc(); cyc(); cyc();
        total++; if ({b_state, b_illegal, b_bus_err} !== {S_TRAP, 2'b10}) begin bad++; $display("FAIL lh_trap got=%b exp=%b", {b_state, b_illegal, b_bus_err}, {S_TRAP, 2'b10}); end
        total++; if ({a_state, a_illegal} !== {S_MEMADR, 1'b0}) begin bad++; $display("FAIL lh_legal got=%b exp=%b", {a_state, a_illegal}, {S_MEMADR, 1'b0}); end
        cyc(); cyc();
        total++; if ({b_state, b_mem_req, b_reg_write, b_pc_write, b_ir_write} !== {S_TRAP, 4'b0000})
            begin bad++; $display("FAIL lh_trap_hold got=%b exp=%b", {b_state, b_mem_req, b_reg_write, b_pc_write, b_ir_write}, {S_TRAP, 4'b0000}); end
        op = 7'b0000000; funct3 = 3'b000;
        do_reset();
        total++; if (b_illegal !== 1'b0) begin bad++; $display("FAIL illegal_cleared got=%b exp=0", b_illegal); end
        cyc(); cyc(); cyc();
        total++; if ({a_state, a_illegal, a_mem_req, a_reg_write, a_pc_write} !== {S_TRAP, 4'b1000})
            begin bad++; $display("FAIL op0_trap got=%b exp=%b", {a_state, a_illegal, a_mem_req, a_reg_write, a_pc_write}, {S_TRAP, 4'b1000}); end
    endtask

    task automatic test_timeout();
        int a_fetch;
        a_fetch = 0;
        op = OP_R; funct3 = 3'd0; funct7 = 1'b0; mem_ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            cyc();
            total++; if ({b_state, b_mem_req} !== {S_FETCH, 1'b1}) begin bad++; $display("FAIL to_stall%0d got=%b exp=%b", i, {b_state, b_mem_req}, {S_FETCH, 1'b1}); end
        end
        cyc();
        total++; if ({b_state, b_bus_err, b_illegal, b_mem_req} !== {S_TRAP, 3'b100})
            begin bad++; $display("FAIL to_trap got=%b exp=%b", {b_state, b_bus_err, b_illegal, b_mem_req}, {S_TRAP, 3'b100}); end
        total++; if ({a_state, a_bus_err} !== {S_FETCH, 1'b0}) begin bad++; $display("FAIL to_default_wait got=%b exp=%b", {a_state, a_bus_err}, {S_FETCH, 1'b0}); end
        for (int i = 6; i <= 15; i++) begin
            cyc();
            if (a_state === S_FETCH) a_fetch++;
        end
        total++; if (a_fetch != 10) begin bad++; $display("FAIL to_default_stalls got=%0d exp=10", a_fetch); end
        cyc();
        total++; if ({a_state, a_bus_err, a_mem_req} !== {S_TRAP, 2'b10}) begin bad++; $display("FAIL to_default_trap got=%b exp=%b", {a_state, a_bus_err, a_mem_req}, {S_TRAP, 2'b10}); end
        mem_ready = 1'b1;
        cyc(); cyc();
        total++; if ({b_state, b_mem_req, b_bus_err} !== {S_TRAP, 2'b01}) begin bad++; $display("FAIL to_sticky got=%b exp=%b", {b_state, b_mem_req, b_bus_err}, {S_TRAP, 2'b01}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_decode();
        test_lbu();
        test_branch();
        test_jumps_upper();
        test_store_reset();
        test_illegal();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
